// File: rtl/reg_file_sb_if.sv
// Decode/writeback bundle for reg_file_sb: read ports, write port, issue strobe
// and the scoreboard status seen by the hazard unit.
interface reg_file_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] A1;
    logic [ADDR_W-1:0] A2;
    logic [ADDR_W-1:0] A3;
    logic [DATA_W-1:0] WD3;
    logic              WE3;
    logic              ISS_EN;
    logic [ADDR_W-1:0] ISS_A;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;
    logic              BUSY1;
    logic              BUSY2;
    logic [ADDR_W:0]   PEND_CNT;

    modport master (
        output A1, A2, A3, WD3, WE3, ISS_EN, ISS_A,
        input  RD1, RD2, BUSY1, BUSY2, PEND_CNT
    );

    modport slave (
        input  A1, A2, A3, WD3, WE3, ISS_EN, ISS_A,
        output RD1, RD2, BUSY1, BUSY2, PEND_CNT
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with optional hardwired zero register and write bypass, plus a
// per-register busy scoreboard and running count of outstanding writes.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic          clk,
    input logic          rst,
    reg_file_sb_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);
    localparam bit BYP   = (BYPASS != 0);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [ADDR_W:0]   r_pend_cnt;

    logic              w_wr_ok;
    logic              w_iss_ok;
    logic [DEPTH-1:0]  w_set;
    logic [DEPTH-1:0]  w_clr;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic              w_inc;
    logic              w_dec;
    logic [ADDR_W:0]   w_pend_nxt;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic              w_busy1;
    logic              w_busy2;

    assign w_wr_ok  = bus.WE3    & ~(ZR & (bus.A3 == ADDR_ZERO));
    assign w_iss_ok = bus.ISS_EN & ~(ZR & (bus.ISS_A == ADDR_ZERO));

    // Per-register set/clear decode; a new issue supersedes a same-edge writeback.
    always_comb begin
        w_set = {DEPTH{1'b0}};
        w_clr = {DEPTH{1'b0}};
        for (int r = 0; r < DEPTH; r++) begin
            w_set[r] = w_iss_ok & (bus.ISS_A == ADDR_W'(r));
            w_clr[r] = bus.WE3  & (bus.A3    == ADDR_W'(r));
        end
        w_busy_nxt = (r_busy & ~w_clr) | w_set;
    end

    // Pending counter moves by at most one per edge, tracking the busy popcount.
    always_comb begin
        w_inc      = w_iss_ok & ~r_busy[bus.ISS_A];
        w_dec      = bus.WE3 & r_busy[bus.A3] & ~(w_iss_ok & (bus.ISS_A == bus.A3));
        w_pend_nxt = r_pend_cnt;
        case ({w_inc, w_dec})
            2'b10:   w_pend_nxt = r_pend_cnt + CNT_ONE;
            2'b01:   w_pend_nxt = r_pend_cnt - CNT_ONE;
            default: w_pend_nxt = r_pend_cnt;
        endcase
    end

    // Register array storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                r_mem[r] <= DATA_ZERO;
            end
        end else if (w_wr_ok) begin
            r_mem[bus.A3] <= bus.WD3;
        end
    end

    // Scoreboard state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= {DEPTH{1'b0}};
            r_pend_cnt <= CNT_ZERO;
        end else begin
            r_busy     <= w_busy_nxt;
            r_pend_cnt <= w_pend_nxt;
        end
    end

    // Read port 1: zero register, then same-cycle forwarding, then storage.
    always_comb begin
        if (rst) begin
            w_rd1 = DATA_ZERO;
        end else if (ZR && (bus.A1 == ADDR_ZERO)) begin
            w_rd1 = DATA_ZERO;
        end else if (BYP && w_wr_ok && (bus.A3 == bus.A1)) begin
            w_rd1 = bus.WD3;
        end else begin
            w_rd1 = r_mem[bus.A1];
        end
    end

    // Read port 2, same priority as port 1.
    always_comb begin
        if (rst) begin
            w_rd2 = DATA_ZERO;
        end else if (ZR && (bus.A2 == ADDR_ZERO)) begin
            w_rd2 = DATA_ZERO;
        end else if (BYP && w_wr_ok && (bus.A3 == bus.A2)) begin
            w_rd2 = bus.WD3;
        end else begin
            w_rd2 = r_mem[bus.A2];
        end
    end

    // A forwarded write supplies the operand, so it no longer counts as busy.
    assign w_busy1 = ~rst & r_busy[bus.A1] & ~(BYP & bus.WE3 & (bus.A3 == bus.A1));
    assign w_busy2 = ~rst & r_busy[bus.A2] & ~(BYP & bus.WE3 & (bus.A3 == bus.A2));

    assign bus.RD1      = w_rd1;
    assign bus.RD2      = w_rd2;
    assign bus.BUSY1    = w_busy1;
    assign bus.BUSY2    = w_busy2;
    assign bus.PEND_CNT = r_pend_cnt;
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: a 32x32 bypassing instance and an 8x16
// non-bypassing instance, checked against an array-based reference model.
module tb_reg_file_sb;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) if_a ();
    reg_file_sb_if #(.DATA_W(16), .ADDR_W(3)) if_b ();

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_a (
        .clk(clk), .rst(rst), .bus(if_a)
    );
    reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .bus(if_b)
    );

    typedef struct {
        int          k;
        int          step;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] b1;
        logic [31:0] b2;
        logic [31:0] pend;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step     = 0;

    // Reference model: storage and busy flags, index 0 = instance a, 1 = instance b
    logic [31:0] m_mem  [2][32];
    bit          m_busy [2][32];
    int          c_a1[2], c_a2[2], c_a3[2], c_ia[2];
    logic [31:0] c_wd[2];
    bit          c_we[2], c_ie[2];

    function automatic int amask(int k);
        return (k == 0) ? 31 : 7;
    endfunction

    function automatic logic [31:0] dmask(int k);
        return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    function automatic int depth(int k);
        return (k == 0) ? 32 : 8;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 32; r++) begin
                m_mem[k][r]  = 32'h0;
                m_busy[k][r] = 1'b0;
            end
    endtask

    function automatic logic [31:0] m_read(int k, int a);
        if (a == 0) return 32'h0;
        if (k == 0 && c_we[k] && c_a3[k] == a) return c_wd[k];
        return m_mem[k][a];
    endfunction

    function automatic logic [31:0] m_busy_q(int k, int a);
        if (a == 0) return 32'h0;
        if (k == 0 && c_we[k] && c_a3[k] == a) return 32'h0;
        return m_busy[k][a] ? 32'h1 : 32'h0;
    endfunction

    function automatic logic [31:0] m_pend(int k);
        int n = 0;
        for (int r = 0; r < depth(k); r++) if (m_busy[k][r]) n++;
        return n;
    endfunction

    // State changes of one clock edge, applied in order so issue wins over clear
    task automatic commit(int k);
        if (c_we[k] && c_a3[k] != 0) m_mem[k][c_a3[k]] = c_wd[k];
        if (c_we[k]) m_busy[k][c_a3[k]] = 1'b0;
        if (c_ie[k] && c_ia[k] != 0) m_busy[k][c_ia[k]] = 1'b1;
    endtask

    task automatic set_in(int k, int a1, int a2, int a3, logic [31:0] wd, bit we, bit ie, int ia);
        c_a1[k] = a1 & amask(k);
        c_a2[k] = a2 & amask(k);
        c_a3[k] = a3 & amask(k);
        c_ia[k] = ia & amask(k);
        c_wd[k] = wd & dmask(k);
        c_we[k] = we;
        c_ie[k] = ie;
        if (k == 0) begin
            if_a.A1 = 5'(c_a1[0]); if_a.A2 = 5'(c_a2[0]); if_a.A3 = 5'(c_a3[0]);
            if_a.ISS_A = 5'(c_ia[0]); if_a.WD3 = c_wd[0];
            if_a.WE3 = we; if_a.ISS_EN = ie;
        end else begin
            if_b.A1 = 3'(c_a1[1]); if_b.A2 = 3'(c_a2[1]); if_b.A3 = 3'(c_a3[1]);
            if_b.ISS_A = 3'(c_ia[1]); if_b.WD3 = c_wd[1][15:0];
            if_b.WE3 = we; if_b.ISS_EN = ie;
        end
    endtask

    task automatic nop(int k);
        set_in(k, 0, 0, 0, 32'h0, 1'b0, 1'b0, 0);
    endtask

    task automatic push_exp();
        exp_t e;
        step++;
        for (int k = 0; k < 2; k++) begin
            e.k    = k;
            e.step = step;
            if (rst) begin
                e.rd1 = 32'h0; e.rd2 = 32'h0; e.b1 = 32'h0; e.b2 = 32'h0; e.pend = 32'h0;
            end else begin
                e.rd1  = m_read(k, c_a1[k]);
                e.rd2  = m_read(k, c_a2[k]);
                e.b1   = m_busy_q(k, c_a1[k]);
                e.b2   = m_busy_q(k, c_a2[k]);
                e.pend = m_pend(k);
            end
            q.push_back(e);
        end
    endtask

    task automatic go();
        push_exp();
        @(posedge clk);
        if (!rst) begin
            commit(0);
            commit(1);
        end
        #1;
    endtask

    task automatic chk(string name, int k, int st, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d step%0d actual=%h expected=%h", name, k, st, act, exp);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, mid-cycle
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.k == 0) begin
                chk("rd1",   0, e.step, if_a.RD1, e.rd1);
                chk("rd2",   0, e.step, if_a.RD2, e.rd2);
                chk("busy1", 0, e.step, {31'h0, if_a.BUSY1}, e.b1);
                chk("busy2", 0, e.step, {31'h0, if_a.BUSY2}, e.b2);
                chk("pend",  0, e.step, {26'h0, if_a.PEND_CNT}, e.pend);
            end else begin
                chk("rd1",   1, e.step, {16'h0, if_b.RD1}, e.rd1);
                chk("rd2",   1, e.step, {16'h0, if_b.RD2}, e.rd2);
                chk("busy1", 1, e.step, {31'h0, if_b.BUSY1}, e.b1);
                chk("busy2", 1, e.step, {31'h0, if_b.BUSY2}, e.b2);
                chk("pend",  1, e.step, {28'h0, if_b.PEND_CNT}, e.pend);
            end
        end
    end

    initial begin
        rst = 1'b1;
        model_reset();
        nop(0); nop(1);
        go(); go();
        rst = 1'b0;

        // Same-cycle write and read of r5: forwarded on a, old value then new on b
        set_in(0, 5, 0, 5, 32'hDEAD_BEEF, 1'b1, 1'b0, 0);
        set_in(1, 5, 0, 5, 32'h0000_BEEF, 1'b1, 1'b0, 0);
        go();
        set_in(0, 5, 5, 0, 32'h0, 1'b0, 1'b0, 0);
        set_in(1, 5, 5, 0, 32'h0, 1'b0, 1'b0, 0);
        go();

        // Zero register ignores writes and issues
        nop(1);
        set_in(0, 0, 5, 0, 32'h1234_5678, 1'b1, 1'b0, 0); go();
        set_in(0, 0, 0, 0, 32'h0, 1'b0, 1'b1, 0); go();
        set_in(0, 0, 0, 0, 32'h0, 1'b0, 1'b0, 0); go();

        // Scoreboard lifecycle on r3 and r7
        set_in(0, 3, 7, 0, 32'h0, 1'b0, 1'b1, 3); go();
        set_in(0, 3, 7, 0, 32'h0, 1'b0, 1'b1, 7); go();
        set_in(0, 3, 7, 0, 32'h0, 1'b0, 1'b0, 0); go();
        set_in(0, 3, 7, 3, 32'hA5A5_0003, 1'b1, 1'b0, 0); go();
        set_in(0, 3, 7, 0, 32'h0, 1'b0, 1'b0, 0); go();

        // Set/clear collision on r4
        set_in(0, 4, 0, 0, 32'h0, 1'b0, 1'b1, 4); go();
        set_in(0, 4, 0, 4, 32'h0000_4444, 1'b1, 1'b1, 4); go();
        set_in(0, 4, 0, 0, 32'h0, 1'b0, 1'b0, 0); go();

        // Small instance: fill, read back, issue every register, re-issue one
        nop(0);
        for (int i = 1; i < 8; i++) begin
            set_in(1, i, i - 1, i, 32'h1000 + 32'(i * 17), 1'b1, 1'b0, 0); go();
        end
        for (int i = 1; i < 8; i++) begin
            set_in(1, i, i + 1, 0, 32'h0, 1'b0, 1'b0, 0); go();
        end
        for (int i = 1; i < 8; i++) begin
            set_in(1, i, 0, 0, 32'h0, 1'b0, 1'b1, i); go();
        end
        set_in(1, 1, 2, 0, 32'h0, 1'b0, 1'b1, 3); go();
        set_in(1, 1, 2, 0, 32'h0, 1'b0, 1'b0, 0); go();

        // Mid-run reset with a write and issue pending on the same edge
        set_in(0, 7, 4, 9, 32'h0000_CAFE, 1'b1, 1'b1, 9);
        set_in(1, 5, 3, 2, 32'h0000_7777, 1'b1, 1'b1, 2);
        rst = 1'b1;
        model_reset();
        go(); go();
        rst = 1'b0;
        set_in(0, 7, 4, 0, 32'h0, 1'b0, 1'b0, 0);
        set_in(1, 5, 3, 0, 32'h0, 1'b0, 1'b0, 0);
        go();

        // Randomised traffic with occasional resets and forced issue/write collisions
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                rst = 1'b1;
                model_reset();
            end else begin
                rst = 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                int a3, ia;
                a3 = int'($urandom_range(0, 31));
                ia = ($urandom_range(0, 3) == 0) ? a3 : int'($urandom_range(0, 31));
                set_in(k, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), a3,
                       $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ia);
            end
            go();
        end

        rst = 1'b0;
        nop(0); nop(1);
        go();
        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual=%0d expected=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the pipeline's register file.
- Configurable data width and depth; optional hardwired-zero register 0; optional write-to-read bypass.
- Adds a per-register busy scoreboard: the issue stage marks a destination pending, and writeback clears it.
- Sits between decode (reads and issue) and writeback (write port). It gives the hazard unit per-operand busy flags and a pending-write count.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes and issues.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports and masks the busy flag.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- A1  in  ADDR_W  read port 1 address.
- A2  in  ADDR_W  read port 2 address.
- A3  in  ADDR_W  write port address.
- WD3  in  DATA_W  write data.
- WE3  in  1  write enable; a write also clears busy[A3].
- ISS_EN  in  1  issue strobe; sets busy[ISS_A].
- ISS_A  in  ADDR_W  destination register being issued.
- RD1  out  DATA_W  read data, port 1 (combinational).
- RD2  out  DATA_W  read data, port 2 (combinational).
- BUSY1  out  1  operand at A1 has an outstanding write.
- BUSY2  out  1  operand at A2 has an outstanding write.
- PEND_CNT  out  ADDR_W+1  number of busy registers.

Behaviour:
- Reset (rst=1, async): all DEPTH registers = 0, all busy bits = 0, PEND_CNT = 0. RD1/RD2 read 0 and BUSY1/BUSY2 = 0 while reset is held. Reset asserted mid-operation overrides any same-edge write or issue.
- Write: on posedge clk with WE3=1, REG[A3] <= WD3. If ZERO_REG=1 and A3=0, the write is discarded.
- Read: RDn = REG[An], combinational, zero latency.
  - ZERO_REG=1 and An=0: RDn = 0.
  - BYPASS=1, WE3=1, A3=An, and the write is not discarded: RDn = WD3 in the same cycle.
  - BYPASS=0: the new value is visible the cycle after the write edge.
- Scoreboard, per register r, on posedge clk:
  - set_r = ISS_EN & (ISS_A==r); clr_r = WE3 & (A3==r).
  - set_r=1: busy[r] <= 1. Set wins over a simultaneous clear, because the new producer supersedes.
  - set_r=0 and clr_r=1: busy[r] <= 0.
  - Otherwise busy[r] holds.
  - ZERO_REG=1: busy[0] is constant 0.
  - Writing a register that is not busy is legal and leaves the busy bit at 0.
- BUSYn = busy[An] & ~(BYPASS & WE3 & (A3==An)).
  - A same-cycle write that is bypassed supplies the data, so the operand is not busy.
  - ZERO_REG=1 and An=0: BUSYn = 0.
- PEND_CNT, on posedge clk:
  - +1 if the issue sets a bit that was 0.
  - -1 if a clear takes effect on a bit that was 1 and the same edge does not set it.
  - Net change is -1..+1 per edge; PEND_CNT always equals the popcount of busy.
  - Range 0..DEPTH (or 0..DEPTH-1 with ZERO_REG=1); it never wraps.
- Simultaneous issue of x and write of y (x != y): both take effect on the same edge.
- Re-issuing a register that is already busy: the bit stays 1 and PEND_CNT is unchanged.

Test Plan:
- Reset: rst=1 pulsed mid-run after writes and issues -> RD1=RD2=0, BUSY1=BUSY2=0, PEND_CNT=0 immediately, without waiting for a clock edge.
- Write/read with bypass: WE3=1, A3=5, WD3=0xDEADBEEF, A1=5 in the same cycle -> RD1=0xDEADBEEF before the edge; with BYPASS=0, the old value before the edge and the new value after it.
- Zero register: WE3=1, A3=0, WD3=0x12345678, then ISS_EN=1, ISS_A=0 -> RD1 (A1=0) = 0, BUSY1=0, PEND_CNT=0.
- Scoreboard lifecycle:
  - Issue r3, then issue r7 -> PEND_CNT=2; BUSY1=1 with A1=3.
  - Write r3 with A1=3 -> BUSY1=0 in the write cycle (BYPASS=1); PEND_CNT=1 after the edge.
- Set/clear collision: busy[4]=1, then ISS_EN (ISS_A=4) and WE3 (A3=4) on the same edge -> busy[4] stays 1, PEND_CNT unchanged, REG[4]=WD3.
- Parameter sweep: DATA_W=16, ADDR_W=3 -> write all 7 non-zero registers with distinct values and read them back correctly; issue all 7 -> PEND_CNT=7 with no overflow.
